// File: rtl/stepper_sequencer.sv
// stepper_sequencer: tiny program sequencer that drives a stepper motor.
// It fetches 8-bit instructions from an external ROM, drives an external
// combinational ALU for accumulator updates, and emits step/direction strobes.
// The ROM is synchronous: instr_data is valid one cycle after instr_addr.
// Optional feature: define STEPPER_WAIT_PRESCALE_EN to slow WAIT by 16x.
// Each WAIT tick then occurs once every 16 clocks.

module stepper_sequencer (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] instr_addr,
  input  logic [7:0] instr_data,
  output logic       alu_add_sub,
  output logic       alu_set_low,
  output logic       alu_set_high,
  output logic [7:0] alu_opa,
  output logic [7:0] alu_opb,
  input  logic [7:0] alu_result,
  output logic       step_pulse,
  output logic       dir,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_JADDR,
    S_WAIT,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_LDL  = 4'h1;
  localparam logic [3:0] OP_LDH  = 4'h2;
  localparam logic [3:0] OP_ADDI = 4'h3;
  localparam logic [3:0] OP_SUBI = 4'h4;
  localparam logic [3:0] OP_JNZ  = 4'h5;
  localparam logic [3:0] OP_STEP = 4'h6;
  localparam logic [3:0] OP_WAIT = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t     state;
  state_t     next_state;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [7:0] acc;
  logic [7:0] wait_cnt;
  logic [3:0] opcode;
  logic       wait_tick;
  logic       wait_enter;
  logic       acc_load;

  assign opcode = ir[7:4];

  // A WAIT with a non-zero accumulator moves into the WAIT state.
  assign wait_enter = (state == S_EXEC) && (opcode == OP_WAIT) && (acc != 8'd0);

  // Accumulator-writing opcodes all take the ALU result.
  assign acc_load = (state == S_EXEC) &&
                    ((opcode == OP_LDL)  || (opcode == OP_LDH) ||
                     (opcode == OP_ADDI) || (opcode == OP_SUBI));

`ifdef STEPPER_WAIT_PRESCALE_EN
  logic [3:0] prescale;

  // Free-running 16-clock prescaler while waiting, restarted on WAIT entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      prescale <= 4'd0;
    end else if (wait_enter) begin
      prescale <= 4'd0;
    end else if (state == S_WAIT) begin
      prescale <= prescale + 4'd1;
    end
  end

  assign wait_tick = (prescale == 4'hF);
`else
  assign wait_tick = 1'b1;
`endif

  // State register; reset aborts whatever is in progress.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: the default assignment up front keeps this block purely
    // combinational; a path that skipped the assignment would infer a latch.
    next_state = state;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_JNZ:  next_state = S_JADDR;
          OP_WAIT: next_state = (acc == 8'd0) ? S_FETCH : S_WAIT;
          OP_HALT: next_state = S_HALT;
          default: next_state = S_FETCH;
        endcase
      end
      S_JADDR: next_state = S_FETCH;
      S_WAIT: begin
        if (wait_tick && (wait_cnt == 8'd1)) begin
          next_state = S_FETCH;
        end
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_FETCH;
    endcase
  end

  // Datapath registers: pc, ir, acc, wait counter and motor direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc       <= 8'd0;
      ir       <= 8'd0;
      acc      <= 8'd0;
      wait_cnt <= 8'd0;
      dir      <= 1'b0;
    end else begin
      if (state == S_DECODE) begin
        ir <= instr_data;
        pc <= pc + 8'd1;
      end
      // JNZ target byte arrives now; not taken just skips over it.
      if (state == S_JADDR) begin
        pc <= (acc != 8'd0) ? instr_data : pc + 8'd1;
      end
      if (acc_load) begin
        acc <= alu_result;
      end
      if (wait_enter) begin
        wait_cnt <= acc;
      end else if ((state == S_WAIT) && wait_tick) begin
        wait_cnt <= wait_cnt - 8'd1;
      end
      if ((state == S_EXEC) && (opcode == OP_STEP)) begin
        dir <= ir[0];
      end
    end
  end

  // Output decode; strobes and the address are held quiet while reset is high.
  always_comb begin
    instr_addr   = pc;
    alu_add_sub  = 1'b0;
    alu_set_low  = 1'b0;
    alu_set_high = 1'b0;
    step_pulse   = 1'b0;
    halted       = 1'b0;
    if (state == S_EXEC) begin
      case (opcode)
        OP_LDL:  alu_set_low  = 1'b1;
        OP_LDH:  alu_set_high = 1'b1;
        OP_SUBI: alu_add_sub  = 1'b1;
        OP_STEP: step_pulse   = 1'b1;
        default: ;
      endcase
    end
    if (state == S_HALT) begin
      halted = 1'b1;
    end
    if (reset) begin
      instr_addr   = 8'd0;
      alu_add_sub  = 1'b0;
      alu_set_low  = 1'b0;
      alu_set_high = 1'b0;
      step_pulse   = 1'b0;
      halted       = 1'b0;
    end
  end

  assign alu_opa = acc;
  assign alu_opb = {4'b0000, ir[3:0]};

endmodule
